// File: rtl/data_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter_if
// Description : OBI-style req/gnt/rvalid data port bundle (one per master/bus).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    // Issuer of requests: drives the request fields, receives grant/response
    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Two-master round-robin arbiter onto one OBI data port, with an
//               ID FIFO routing each response back to its issuing master.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int MAX_OUTST = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    data_bus_arbiter_if.slave   m0,
    data_bus_arbiter_if.slave   m1,
    data_bus_arbiter_if.master  s,
    output logic                err_o
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(MAX_OUTST);
    localparam logic             c_ID_M0    = 1'b0;
    localparam logic             c_ID_M1    = 1'b1;

    logic             r_id_mem [MAX_OUTST];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_prio;
    logic             r_err;

    logic w_empty;
    logic w_full;
    logic w_eligible;
    logic w_win_valid;
    logic w_win_id;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_stray;
    logic w_head;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_head  = r_id_mem[r_rptr];

    // A same-cycle response frees a slot, so a full FIFO can still accept
    assign w_eligible  = ~w_full | s.rvalid;
    assign w_win_valid = m0.req | m1.req;
    assign w_win_id    = (m0.req & m1.req) ? r_prio : (m1.req ? c_ID_M1 : c_ID_M0);

    assign w_sel   = w_win_valid & ~rst_i;
    assign w_push  = s.req & s.gnt;
    assign w_pop   = s.rvalid & ~w_empty & ~rst_i;
    assign w_stray = s.rvalid & w_empty;

    // ------------------------------------------------------------------
    // Request path to the bus
    // ------------------------------------------------------------------
    always_comb begin
        s.req   = w_sel & w_eligible;
        s.we    = 1'b0;
        s.be    = '0;
        s.addr  = '0;
        s.wdata = '0;
        if (w_sel) begin
            if (w_win_id == c_ID_M1) begin
                s.we    = m1.we;
                s.be    = m1.be;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
            end else begin
                s.we    = m0.we;
                s.be    = m0.be;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
            end
        end
    end

    assign m0.gnt = w_push & (w_win_id == c_ID_M0);
    assign m1.gnt = w_push & (w_win_id == c_ID_M1);

    // ------------------------------------------------------------------
    // Response routing by FIFO head
    // ------------------------------------------------------------------
    assign m0.rvalid = w_pop & (w_head == c_ID_M0);
    assign m1.rvalid = w_pop & (w_head == c_ID_M1);
    assign m0.rdata  = m0.rvalid ? s.rdata : '0;
    assign m1.rdata  = m1.rvalid ? s.rdata : '0;

    assign err_o = r_err;

    // ------------------------------------------------------------------
    // ID FIFO storage (contents need no reset; occupancy guards reads)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id_mem[r_wptr] <= w_win_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_prio  <= c_ID_M0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= f_ptr_inc(r_wptr);
                r_prio <= ~w_win_id;
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_arbiter
// Description : Directed self-checking bench for data_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

    logic clk;
    logic rst;
    logic err;
    int   n_checks;
    int   n_errors;

    data_bus_arbiter_if m0_bus ();
    data_bus_arbiter_if m1_bus ();
    data_bus_arbiter_if s_bus ();

    data_bus_arbiter #(.MAX_OUTST(2)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let new inputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        m0_bus.req = 0; m0_bus.we = 0; m0_bus.be = 0; m0_bus.addr = 0; m0_bus.wdata = 0;
        m1_bus.req = 0; m1_bus.we = 0; m1_bus.be = 0; m1_bus.addr = 0; m1_bus.wdata = 0;
        s_bus.gnt = 1; s_bus.rvalid = 0; s_bus.rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1;
        idle_inputs();

        // Reset state with live-looking traffic on the inputs
        tick();
        m0_bus.req = 1; m1_bus.req = 1; s_bus.rvalid = 1; s_bus.rdata = 32'hFFFF_FFFF;
        settle();
        check_value("rst_s_req",     s_bus.req,     0);
        check_value("rst_s_addr",    s_bus.addr,    0);
        check_value("rst_m0_gnt",    m0_bus.gnt,    0);
        check_value("rst_m1_gnt",    m1_bus.gnt,    0);
        check_value("rst_m0_rvalid", m0_bus.rvalid, 0);
        check_value("rst_m0_rdata",  m0_bus.rdata,  0);
        check_value("rst_m1_rdata",  m1_bus.rdata,  0);
        tick();
        check_value("rst_err", err, 0);
        do_reset();

        // Single m0 read with one-cycle response
        m0_bus.req = 1; m0_bus.addr = 32'h0000_0010;
        settle();
        check_value("t1_m0_gnt",  m0_bus.gnt, 1);
        check_value("t1_m1_gnt",  m1_bus.gnt, 0);
        check_value("t1_s_req",   s_bus.req,  1);
        check_value("t1_s_addr",  s_bus.addr, 32'h0000_0010);
        check_value("t1_s_we",    s_bus.we,   0);
        tick();
        m0_bus.req = 0; s_bus.rvalid = 1; s_bus.rdata = 32'hDEAD_BEEF;
        settle();
        check_value("t1_m0_rvalid", m0_bus.rvalid, 1);
        check_value("t1_m0_rdata",  m0_bus.rdata,  32'hDEAD_BEEF);
        check_value("t1_m1_rvalid", m1_bus.rvalid, 0);
        check_value("t1_m1_rdata",  m1_bus.rdata,  0);
        tick();

        // Both masters continuously: grants m0,m1,m0,m1, responses in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            m0_bus.req   = (i < 4);
            m1_bus.req   = (i < 4);
            s_bus.rvalid = (i > 0);
            s_bus.rdata  = 32'h0000_0100 + 32'(i);
            settle();
            if (i < 4) begin
                check_value($sformatf("t2_m0_gnt_%0d", i), m0_bus.gnt, 32'((i % 2) == 0));
                check_value($sformatf("t2_m1_gnt_%0d", i), m1_bus.gnt, 32'((i % 2) == 1));
            end
            if (i > 0) begin
                check_value($sformatf("t2_m0_rvalid_%0d", i), m0_bus.rvalid, 32'(((i - 1) % 2) == 0));
                check_value($sformatf("t2_m1_rvalid_%0d", i), m1_bus.rvalid, 32'(((i - 1) % 2) == 1));
                if (((i - 1) % 2) == 0)
                    check_value($sformatf("t2_m0_rdata_%0d", i), m0_bus.rdata, 32'h0000_0100 + 32'(i));
                else
                    check_value($sformatf("t2_m1_rdata_%0d", i), m1_bus.rdata, 32'h0000_0100 + 32'(i));
            end
            tick();
        end
        idle_inputs();

        // m1 write alone
        m1_bus.req = 1; m1_bus.we = 1; m1_bus.be = 4'b0011;
        m1_bus.addr = 32'h0001_0000; m1_bus.wdata = 32'h1234_ABCD;
        settle();
        check_value("t3_s_we",    s_bus.we,    1);
        check_value("t3_s_be",    s_bus.be,    4'b0011);
        check_value("t3_s_addr",  s_bus.addr,  32'h0001_0000);
        check_value("t3_s_wdata", s_bus.wdata, 32'h1234_ABCD);
        check_value("t3_m1_gnt",  m1_bus.gnt,  1);
        check_value("t3_m0_gnt",  m0_bus.gnt,  0);
        tick();
        idle_inputs();
        s_bus.rvalid = 1; s_bus.rdata = 32'h0000_5A5A;
        settle();
        check_value("t3_m1_rvalid", m1_bus.rvalid, 1);
        check_value("t3_m0_rvalid", m0_bus.rvalid, 0);
        tick();
        idle_inputs();
        settle();
        check_value("t3_err", err, 0);

        // FIFO full back-pressure with MAX_OUTST=2
        do_reset();
        m0_bus.req = 1; m1_bus.req = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_value($sformatf("t4_s_req_%0d", i),  s_bus.req,  32'(i < 2));
            check_value($sformatf("t4_m0_gnt_%0d", i), m0_bus.gnt, 32'(i == 0));
            check_value($sformatf("t4_m1_gnt_%0d", i), m1_bus.gnt, 32'(i == 1));
            tick();
        end
        s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0777;
        settle();
        check_value("t4_pop_m0_rvalid", m0_bus.rvalid, 1);
        check_value("t4_pop_m0_rdata",  m0_bus.rdata,  32'h0000_0777);
        check_value("t4_pop_m0_gnt",    m0_bus.gnt,    1);
        check_value("t4_pop_m1_gnt",    m1_bus.gnt,    0);
        tick();

        // Reset with 2 outstanding (m1, m0) and priority pointing at m1
        rst = 1; s_bus.rvalid = 1; m0_bus.req = 0; m1_bus.req = 1;
        settle();
        check_value("t6_rst_m1_gnt",    m1_bus.gnt,    0);
        check_value("t6_rst_m1_rvalid", m1_bus.rvalid, 0);
        check_value("t6_rst_s_req",     s_bus.req,     0);
        tick();
        tick();
        rst = 0; s_bus.rvalid = 0; m0_bus.req = 1; m1_bus.req = 1;
        settle();
        check_value("t6_post_m0_gnt", m0_bus.gnt, 1);
        check_value("t6_post_m1_gnt", m1_bus.gnt, 0);
        check_value("t6_post_err",    err,        0);
        tick();
        m0_bus.req = 0;
        settle();
        check_value("t6_m1_only_gnt", m1_bus.gnt, 1);
        tick();
        m1_bus.req = 0; s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0AAA;
        settle();
        check_value("t6_resp_m0", m0_bus.rvalid, 1);
        tick();
        settle();
        check_value("t6_resp_m1", m1_bus.rvalid, 1);
        tick();

        // Stray response: dropped, sticky err from next cycle
        s_bus.rvalid = 1; s_bus.rdata = 32'h0BAD_0BAD;
        settle();
        check_value("t5_m0_rvalid", m0_bus.rvalid, 0);
        check_value("t5_m1_rvalid", m1_bus.rvalid, 0);
        check_value("t5_err_same",  err,           0);
        tick();
        s_bus.rvalid = 0;
        settle();
        check_value("t5_err_next", err, 1);
        tick();
        tick();
        check_value("t5_err_sticky", err, 1);
        do_reset();
        settle();
        check_value("t5_err_cleared", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
